// File: rtl/pwm_width_meter.sv
`default_nettype none
// ============================================================================
// Module   : pwm_width_meter
// Brief    : Measures high and low widths of a clk-synchronous PWM waveform,
//            publishing one measurement per completed period.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_width_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_width,
    output logic [WIDTH-1:0] low_width,
    output logic             meas_valid,
    output logic             overflow,
    output logic             ratio_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic             pwm_d;
    logic [WIDTH-1:0] hi_cnt;
    logic [WIDTH-1:0] lo_cnt;
    logic             sat;

    logic rise;
    logic fall;
    logic hi_max;
    logic lo_max;
    logic ratio_now;

    assign rise   = pwm_in & ~pwm_d;
    assign fall   = ~pwm_in & pwm_d;
    assign hi_max = (hi_cnt == CNT_MAX);
    assign lo_max = (lo_cnt == CNT_MAX);

    // One extra bit so doubling hi_cnt cannot lose its MSB.
    assign ratio_now = ({1'b0, lo_cnt} == {hi_cnt, 1'b0}) & ~sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pwm_d      <= 1'b0;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            sat        <= 1'b0;
            high_width <= '0;
            low_width  <= '0;
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
            ratio_ok   <= 1'b0;
        end else begin
            pwm_d      <= pwm_in;
            meas_valid <= 1'b0;
            if (!en) begin
                state  <= IDLE;
                hi_cnt <= '0;
                lo_cnt <= '0;
                sat    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state  <= HIGH;
                            hi_cnt <= CNT_ONE;
                            lo_cnt <= '0;
                            sat    <= 1'b0;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state  <= LOW;
                            lo_cnt <= CNT_ONE;
                        end else if (pwm_in) begin
                            if (hi_max) sat    <= 1'b1;
                            else        hi_cnt <= hi_cnt + CNT_ONE;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            high_width <= hi_cnt;
                            low_width  <= lo_cnt;
                            overflow   <= sat;
                            ratio_ok   <= ratio_now;
                            meas_valid <= 1'b1;
                            state      <= HIGH;
                            hi_cnt     <= CNT_ONE;
                            lo_cnt     <= '0;
                            sat        <= 1'b0;
                        end else if (!pwm_in) begin
                            if (lo_max) sat    <= 1'b1;
                            else        lo_cnt <= lo_cnt + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
